// File: rtl/coherent_cache_array.sv
// Set-associative line array with MSI(E) snoop port and per-set true LRU.
// Build option: define COHERENT_CACHE_EXCL_EN to store and report EXCLUSIVE.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   addr, rd_en, wr_en          local lookup / line write (shared address)
//   wr_data, wr_state           line contents and state for a write
//   hit, rd_data, rd_state      registered lookup result, held until next rd_en
//   evict_dirty, evict_tag      victim description on a lookup miss
//   snp_valid, snp_addr, snp_inv   snoop request (BusRd / BusRdX)
//   snp_hit, snp_dirty, snp_data   one-cycle snoop response

package coherent_cache_pkg;
    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        MODIFIED  = 2'd2,
        EXCLUSIVE = 2'd3
    } blk_state_t;
endpackage

module coherent_cache_array
    import coherent_cache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int TAG_W  = 5,
    parameter int LINE_W = 64,
    localparam int IW    = $clog2(SETS),
    localparam int AW    = TAG_W + IW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_data,
    input  logic [1:0]        wr_state,
    output logic              hit,
    output logic [LINE_W-1:0] rd_data,
    output logic [1:0]        rd_state,
    output logic              evict_dirty,
    output logic [TAG_W-1:0]  evict_tag,
    input  logic              snp_valid,
    input  logic [AW-1:0]     snp_addr,
    input  logic              snp_inv,
    output logic              snp_hit,
    output logic              snp_dirty,
    output logic [LINE_W-1:0] snp_data
);

    localparam int LW = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [LINE_W-1:0] data_q [SETS][WAYS];
    logic [1:0]        st_q   [SETS][WAYS];

    logic              hit_q;
    logic [LINE_W-1:0] rd_data_q;
    logic [1:0]        rd_state_q;
    logic              evict_dirty_q;
    logic [TAG_W-1:0]  evict_tag_q;
    logic              snp_hit_q;
    logic              snp_dirty_q;
    logic [LINE_W-1:0] snp_data_q;

    logic [IW-1:0]     ridx;
    logic [IW-1:0]     sidx;
    logic [TAG_W-1:0]  rtag;
    logic [TAG_W-1:0]  stag;

    assign ridx = addr[IW-1:0];
    assign rtag = addr[AW-1:IW];
    assign sidx = snp_addr[IW-1:0];
    assign stag = snp_addr[AW-1:IW];

    logic [1:0] wst;

`ifdef COHERENT_CACHE_EXCL_EN
    assign wst = wr_state;
`else
    assign wst = (wr_state == EXCLUSIVE) ? SHARED : wr_state;
`endif

    logic          rd_hit;
    logic          inv_found;
    logic          s_hit;
    logic [LW-1:0] rd_hw;
    logic [LW-1:0] inv_w;
    logic [LW-1:0] s_hw;
    logic [LW-1:0] lru_w;
    logic [LW-1:0] vic_w;
    logic [LW-1:0] tgt_w;

    // Descending scan so the lowest-index match wins.
    always_comb begin
        rd_hit    = 1'b0;
        rd_hw     = '0;
        inv_found = 1'b0;
        inv_w     = '0;
        s_hit     = 1'b0;
        s_hw      = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (st_q[ridx][w] != INVALID && tag_q[ridx][w] == rtag) begin
                rd_hit = 1'b1;
                rd_hw  = LW'(w);
            end
            if (st_q[ridx][w] == INVALID) begin
                inv_found = 1'b1;
                inv_w     = LW'(w);
            end
            if (st_q[sidx][w] != INVALID && tag_q[sidx][w] == stag) begin
                s_hit = 1'b1;
                s_hw  = LW'(w);
            end
        end
    end

    assign vic_w = inv_found ? inv_w : lru_w;
    assign tgt_w = rd_hit ? rd_hw : vic_w;

    logic              coll;
    logic              s_pre_hit;
    logic              snp_upd;
    logic [1:0]        s_pre_st;
    logic [1:0]        s_new;
    logic [LW-1:0]     s_way;
    logic [LINE_W-1:0] s_data;

    // A colliding write is applied first, so the snoop sees the new line.
    // A non-colliding write that evicts the snooped way overrides the snoop.
    always_comb begin
        coll      = wr_en && snp_valid && (snp_addr == addr);
        s_way     = coll ? tgt_w : s_hw;
        s_pre_st  = INVALID;
        if (coll) begin
            s_pre_st = wst;
        end else if (s_hit) begin
            s_pre_st = st_q[sidx][s_hw];
        end
        s_pre_hit = (s_pre_st != INVALID);
        s_data    = coll ? wr_data : data_q[sidx][s_hw];
        if (snp_inv) begin
            s_new = INVALID;
        end else if (s_pre_st == MODIFIED || s_pre_st == EXCLUSIVE) begin
            s_new = SHARED;
        end else begin
            s_new = s_pre_st;
        end
        snp_upd = snp_valid && s_pre_hit &&
                  !(wr_en && !coll && sidx == ridx && s_way == tgt_w);
    end

    // On a read hit tgt_w is the hitting way, so one touch path covers both.
    logic touch;
    assign touch = wr_en || (rd_en && rd_hit);

    generate
        if (WAYS > 1) begin : g_lru
            // age 0 is MRU, age WAYS-1 is LRU.
            logic [LW-1:0] age_q [SETS][WAYS];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) begin
                            age_q[s][w] <= LW'(w);
                        end
                    end
                end else if (touch) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (age_q[ridx][w] < age_q[ridx][tgt_w]) begin
                            age_q[ridx][w] <= age_q[ridx][w] + LW'(1);
                        end
                    end
                    age_q[ridx][tgt_w] <= '0;
                end
            end

            always_comb begin
                lru_w = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (age_q[ridx][w] == LW'(WAYS - 1)) begin
                        lru_w = LW'(w);
                    end
                end
            end
        end else begin : g_nolru
            assign lru_w = '0;
        end
    endgenerate

    // Tag/data are not cleared by reset; state alone marks validity.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            tag_q[ridx][tgt_w]  <= rtag;
            data_q[ridx][tgt_w] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    st_q[s][w] <= INVALID;
                end
            end
        end else begin
            if (wr_en) begin
                st_q[ridx][tgt_w] <= wst;
            end
            if (snp_upd) begin
                st_q[sidx][s_way] <= s_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q         <= 1'b0;
            rd_data_q     <= '0;
            rd_state_q    <= INVALID;
            evict_dirty_q <= 1'b0;
            evict_tag_q   <= '0;
            snp_hit_q     <= 1'b0;
            snp_dirty_q   <= 1'b0;
            snp_data_q    <= '0;
        end else begin
            if (rd_en) begin
                hit_q         <= rd_hit;
                rd_data_q     <= data_q[ridx][tgt_w];
                rd_state_q    <= st_q[ridx][tgt_w];
                evict_dirty_q <= !rd_hit && (st_q[ridx][tgt_w] == MODIFIED);
                evict_tag_q   <= (!rd_hit && st_q[ridx][tgt_w] != INVALID)
                                 ? tag_q[ridx][tgt_w] : '0;
            end
            snp_hit_q   <= snp_valid && s_pre_hit;
            snp_dirty_q <= snp_valid && (s_pre_st == MODIFIED);
            snp_data_q  <= (snp_valid && s_pre_hit) ? s_data : '0;
        end
    end

    assign hit         = hit_q;
    assign rd_data     = rd_data_q;
    assign rd_state    = rd_state_q;
    assign evict_dirty = evict_dirty_q;
    assign evict_tag   = evict_tag_q;
    assign snp_hit     = snp_hit_q;
    assign snp_dirty   = snp_dirty_q;
    assign snp_data    = snp_data_q;

endmodule

// File: tb/tb_coherent_cache_array.sv
// Bench for coherent_cache_array: directed scenarios plus random traffic
// against a line/recency-list model of the cache.
module tb_coherent_cache_array;

    localparam int WAYS   = 2;
    localparam int SETS   = 64;
    localparam int TAG_W  = 5;
    localparam int LINE_W = 64;
    localparam int IW     = 6;
    localparam int AW     = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic              rd_en = 1'b0;
    logic              wr_en = 1'b0;
    logic [LINE_W-1:0] wr_data = '0;
    logic [1:0]        wr_state = '0;
    logic              hit;
    logic [LINE_W-1:0] rd_data;
    logic [1:0]        rd_state;
    logic              evict_dirty;
    logic [TAG_W-1:0]  evict_tag;
    logic              snp_valid = 1'b0;
    logic [AW-1:0]     snp_addr = '0;
    logic              snp_inv = 1'b0;
    logic              snp_hit;
    logic              snp_dirty;
    logic [LINE_W-1:0] snp_data;

    always #5 clk = ~clk;

    coherent_cache_array #(
        .WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en),
        .wr_en(wr_en), .wr_data(wr_data), .wr_state(wr_state),
        .hit(hit), .rd_data(rd_data), .rd_state(rd_state),
        .evict_dirty(evict_dirty), .evict_tag(evict_tag),
        .snp_valid(snp_valid), .snp_addr(snp_addr), .snp_inv(snp_inv),
        .snp_hit(snp_hit), .snp_dirty(snp_dirty), .snp_data(snp_data)
    );

    int checks = 0;
    int errs   = 0;

    // Model: per line {state, tag, data}; per set a recency list, [0] = MRU.
    logic [1:0]        m_st  [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag [SETS][WAYS];
    logic [LINE_W-1:0] m_dat [SETS][WAYS];
    int                m_lst [SETS][WAYS];

    logic              e_hit, e_edirty, e_vvalid, e_shit, e_sdirty;
    logic [1:0]        e_state;
    logic [LINE_W-1:0] e_data, e_sdata;
    logic [TAG_W-1:0]  e_etag;

    function automatic logic [1:0] stored_state(logic [1:0] s);
`ifdef COHERENT_CACHE_EXCL_EN
        return s;
`else
        return (s == 2'd3) ? 2'd1 : s;
`endif
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_st[s][w]  = 2'd0;
                m_lst[s][w] = w;
            end
        end
        e_hit = 0; e_edirty = 0; e_vvalid = 1; e_shit = 0; e_sdirty = 0;
        e_state = 0; e_data = 0; e_sdata = 0; e_etag = 0;
    endtask

    task automatic m_find(input int s, input logic [TAG_W-1:0] t,
                          output bit f, output int w);
        f = 0;
        w = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (!f && m_st[s][i] != 2'd0 && m_tag[s][i] == t) begin
                f = 1;
                w = i;
            end
        end
    endtask

    task automatic m_touch(input int s, input int w);
        int p = 0;
        for (int k = 0; k < WAYS; k++) if (m_lst[s][k] == w) p = k;
        for (int k = p; k > 0; k--) m_lst[s][k] = m_lst[s][k-1];
        m_lst[s][0] = w;
    endtask

    // Drives one cycle of stimulus, advances the model and the clock.
    task automatic cycle(input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [LINE_W-1:0] d, input logic [1:0] st,
                         input bit sv, input logic [AW-1:0] sa, input bit si);
        int s, ss, hw, vw, sw, tw, pw;
        bit h, sh, ph;
        logic [1:0] pre, mst;
        logic [LINE_W-1:0] pd;
        rd_en = r; wr_en = w; addr = a; wr_data = d; wr_state = st;
        snp_valid = sv; snp_addr = sa; snp_inv = si;
        s  = int'(a[IW-1:0]);
        ss = int'(sa[IW-1:0]);
        m_find(s, a[AW-1:IW], h, hw);
        vw = m_lst[s][WAYS-1];
        for (int i = WAYS - 1; i >= 0; i--) if (m_st[s][i] == 2'd0) vw = i;
        m_find(ss, sa[AW-1:IW], sh, sw);
        pre = sh ? m_st[ss][sw] : 2'd0;
        pd  = m_dat[ss][sw];
        if (r) begin
            e_hit = h;
            if (h) begin
                e_data = m_dat[s][hw]; e_state = m_st[s][hw];
                e_edirty = 0; e_etag = 0; e_vvalid = 1;
            end else begin
                e_data = m_dat[s][vw]; e_state = m_st[s][vw];
                e_edirty = (m_st[s][vw] == 2'd2); e_etag = m_tag[s][vw];
                e_vvalid = (m_st[s][vw] != 2'd0);
            end
        end
        mst = stored_state(st);
        if (w) begin
            tw = h ? hw : vw;
            m_st[s][tw] = mst; m_tag[s][tw] = a[AW-1:IW]; m_dat[s][tw] = d;
            m_touch(s, tw);
        end else if (r && h) begin
            m_touch(s, hw);
        end
        if (w && sv && a == sa) begin
            pre = mst;
            pd  = d;
        end
        if (sv) begin
            e_shit = (pre != 2'd0); e_sdirty = (pre == 2'd2);
            e_sdata = (pre != 2'd0) ? pd : '0;
            m_find(ss, sa[AW-1:IW], ph, pw);
            if (ph) begin
                if (si) m_st[ss][pw] = 2'd0;
                else if (m_st[ss][pw] >= 2'd2) m_st[ss][pw] = 2'd1;
            end
        end else begin
            e_shit = 0; e_sdirty = 0; e_sdata = '0;
        end
        @(posedge clk);
        #1;
        rd_en = 0; wr_en = 0; snp_valid = 0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 0; addr = 11'h041; wr_data = 64'hDEAD; wr_state = 2'd2;
        rd_en = 1; wr_en = 1; snp_valid = 1; snp_addr = 11'h041;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1; rd_en = 0; wr_en = 0; snp_valid = 0;
        #1;
        checks++;
        if ({hit, rd_state, evict_dirty, evict_tag, snp_hit, snp_dirty} !== '0) begin
            errs++;
            $display("FAIL reset_flags: got %b want 0",
                     {hit, rd_state, evict_dirty, evict_tag, snp_hit, snp_dirty});
        end
        checks++;
        if ({rd_data, snp_data} !== '0) begin
            errs++;
            $display("FAIL reset_data: got %h want 0", {rd_data, snp_data});
        end
    endtask

    task automatic test_directed();
        cycle(1, 0, 11'h041, 0, 0, 0, 0, 0);
        checks++;
        if ({hit, rd_state, evict_dirty} !== 4'b0000) begin
            errs++;
            $display("FAIL first_miss: got %b want 0000", {hit, rd_state, evict_dirty});
        end
        cycle(0, 1, 11'h041, 64'h1111, 2'd2, 0, 0, 0);
        cycle(1, 0, 11'h041, 0, 0, 0, 0, 0);
        checks++;
        if ({hit, rd_state} !== 3'b110 || rd_data !== 64'h1111) begin
            errs++;
            $display("FAIL write_hit: got %b/%h want 110/1111", {hit, rd_state}, rd_data);
        end
        cycle(0, 1, 11'h081, 64'h2222, 2'd1, 0, 0, 0);
        cycle(1, 0, 11'h041, 0, 0, 0, 0, 0);
        cycle(1, 0, 11'h0C1, 0, 0, 0, 0, 0);
        checks++;
        if (hit !== 1'b0 || evict_tag !== 5'd2 || evict_dirty !== 1'b0) begin
            errs++;
            $display("FAIL lru_victim: got hit=%b tag=%0d dirty=%b want 0/2/0",
                     hit, evict_tag, evict_dirty);
        end
        cycle(0, 0, 0, 0, 0, 1, 11'h041, 0);
        checks++;
        if ({snp_hit, snp_dirty} !== 2'b11 || snp_data !== 64'h1111) begin
            errs++;
            $display("FAIL snoop_rd: got %b/%h want 11/1111", {snp_hit, snp_dirty}, snp_data);
        end
        cycle(1, 0, 11'h041, 0, 0, 0, 0, 0);
        checks++;
        if ({snp_hit, snp_dirty} !== 2'b00 || snp_data !== '0) begin
            errs++;
            $display("FAIL snoop_pulse: got %b/%h want 00/0", {snp_hit, snp_dirty}, snp_data);
        end
        checks++;
        if ({hit, rd_state} !== 3'b101) begin
            errs++;
            $display("FAIL downgrade: got %b want 101", {hit, rd_state});
        end
        cycle(0, 1, 11'h0C1, 64'h3333, 2'd1, 1, 11'h0C1, 1);
        checks++;
        if (snp_hit !== 1'b1 || snp_data !== 64'h3333) begin
            errs++;
            $display("FAIL collision: got %b/%h want 1/3333", snp_hit, snp_data);
        end
        cycle(1, 0, 11'h0C1, 0, 0, 0, 0, 0);
        checks++;
        if (hit !== 1'b0) begin
            errs++;
            $display("FAIL collision_inv: got hit=%b want 0", hit);
        end
        cycle(1, 0, 11'h041, 0, 0, 1, 11'h041, 1);
        checks++;
        if ({hit, rd_state, snp_hit} !== 4'b1011) begin
            errs++;
            $display("FAIL lookup_presnoop: got %b want 1011", {hit, rd_state, snp_hit});
        end
        cycle(1, 0, 11'h041, 0, 0, 0, 0, 0);
        checks++;
        if (hit !== 1'b0) begin
            errs++;
            $display("FAIL snoop_inv: got hit=%b want 0", hit);
        end
    endtask

    task automatic test_exclusive();
        cycle(0, 1, 11'h082, 64'h4444, 2'd3, 0, 0, 0);
        cycle(1, 0, 11'h082, 0, 0, 0, 0, 0);
`ifdef COHERENT_CACHE_EXCL_EN
        checks++;
        if ({hit, rd_state} !== 3'b111) begin
            errs++;
            $display("FAIL excl_store: got %b want 111", {hit, rd_state});
        end
        cycle(0, 0, 0, 0, 0, 1, 11'h082, 0);
        checks++;
        if ({snp_hit, snp_dirty} !== 2'b10) begin
            errs++;
            $display("FAIL excl_snoop: got %b want 10", {snp_hit, snp_dirty});
        end
        cycle(1, 0, 11'h082, 0, 0, 0, 0, 0);
`endif
        checks++;
        if ({hit, rd_state} !== 3'b101) begin
            errs++;
            $display("FAIL excl_shared: got %b want 101", {hit, rd_state});
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a, sa;
        for (int n = 0; n < 600; n++) begin
            a  = {TAG_W'($urandom_range(0, 3)), IW'($urandom_range(0, 3))};
            sa = ($urandom_range(0, 1) == 1) ? a
                 : {TAG_W'($urandom_range(0, 3)), IW'($urandom_range(0, 3))};
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), sa, 1'($urandom_range(0, 1)));
            checks++;
            if ({hit, rd_state, evict_dirty, snp_hit, snp_dirty} !==
                {e_hit, e_state, e_edirty, e_shit, e_sdirty}) begin
                errs++;
                $display("FAIL rnd_flags@%0d: got %b want %b", n,
                         {hit, rd_state, evict_dirty, snp_hit, snp_dirty},
                         {e_hit, e_state, e_edirty, e_shit, e_sdirty});
            end
            checks++;
            if (snp_data !== e_sdata) begin
                errs++;
                $display("FAIL rnd_snp_data@%0d: got %h want %h", n, snp_data, e_sdata);
            end
            if (e_vvalid) begin
                checks++;
                if (rd_data !== e_data || evict_tag !== e_etag) begin
                    errs++;
                    $display("FAIL rnd_line@%0d: got %h/%0d want %h/%0d", n,
                             rd_data, evict_tag, e_data, e_etag);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 1, 11'h043, 64'h5555, 2'd2, 0, 0, 0);
        cycle(1, 0, 11'h043, 0, 0, 1, 11'h043, 0);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({hit, rd_state, snp_hit, snp_dirty} !== '0 || {rd_data, snp_data} !== '0) begin
            errs++;
            $display("FAIL async_reset: got %b/%h want 0",
                     {hit, rd_state, snp_hit, snp_dirty}, {rd_data, snp_data});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle(1, 0, 11'h043, 0, 0, 0, 0, 0);
        checks++;
        if ({hit, rd_state} !== 3'b000) begin
            errs++;
            $display("FAIL post_reset_miss: got %b want 000", {hit, rd_state});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exclusive();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule

// File: doc/coherent_cache_array.md
COHERENT_CACHE_ARRAY -- requirements
Module: coherent_cache_array

Interface
REQ-001 WAYS, default 2: associativity, legal values 1, 2 or 4.
REQ-002 SETS, default 64: sets per way, power of two; IW = log2(SETS).
REQ-003 TAG_W, default 5: tag width; AW = TAG_W + IW.
REQ-004 LINE_W, default 64: line data width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 addr  in  AW  local line address; index = addr[IW-1:0], tag = addr[AW-1:IW].
REQ-008 rd_en  in  1  local lookup request.
REQ-009 wr_en  in  1  local line write.
REQ-010 wr_data  in  LINE_W  line to write.
REQ-011 wr_state  in  2  state to write, blk_state_t {INVALID=0, SHARED=1, MODIFIED=2, EXCLUSIVE=3}.
REQ-012 hit  out  1  registered lookup hit.
REQ-013 rd_data  out  LINE_W  hitting line, or victim line on miss.
REQ-014 rd_state  out  2  state of the line driven on rd_data.
REQ-015 evict_dirty  out  1  miss victim is MODIFIED.
REQ-016 evict_tag  out  TAG_W  miss victim tag.
REQ-017 snp_valid  in  1  snoop from other core.
REQ-018 snp_addr  in  AW  snooped line address.
REQ-019 snp_inv  in  1  0 = BusRd, 1 = BusRdX/invalidate.
REQ-020 snp_hit  out  1  snooped line present (state != INVALID).
REQ-021 snp_dirty  out  1  snooped line was MODIFIED before the snoop.
REQ-022 snp_data  out  LINE_W  snooped line data.

Function
REQ-023 Lookup: rd_en sampled at edge N; hit/rd_data/rd_state/evict_* valid after edge N, held until next rd_en edge.
REQ-024 Hit = some way in the set has matching tag and state != INVALID; rd_data/rd_state come from that way; evict_* = 0 on hit.
REQ-025 Miss: hit=0; rd_data, rd_state, evict_tag, evict_dirty describe the LRU victim way (an INVALID way is chosen before any valid way, lowest index first).
REQ-026 Write: wr_en at edge N stores {wr_state, tag, wr_data} into the tag-hitting way, else the victim per REQ-025; wr_state INVALID is a legal eviction.
REQ-027 rd_en and wr_en in one cycle: lookup returns pre-write contents (read-before-write).
REQ-028 LRU: per-set true LRU, log2(WAYS)-bit age per way; read hit and write make the accessed way MRU; snoops never touch LRU; WAYS=1 has no LRU state.
REQ-029 Snoop: snp_valid at edge N; snp_hit/snp_dirty/snp_data valid for exactly one cycle after edge N, then 0.
REQ-030 Snoop miss: snp_hit=0, snp_dirty=0, snp_data=0; array unchanged.
REQ-031 Snoop hit state update at edge N: snp_inv=0: MODIFIED->SHARED, SHARED unchanged; snp_inv=1: any->INVALID; tag/data unchanged.
REQ-032 Collision, local write and snoop to same set and tag at one edge: write applied first, REQ-031 transform applied to the written state; snp_data = wr_data.
REQ-033 Snoop and lookup to same line at one edge: lookup returns the pre-snoop state.

Reset
REQ-034 rst_n low: all way states INVALID, all LRU ages reset to way index, all outputs 0, immediately and independent of clk; tag/data arrays not cleared.
REQ-035 Requests asserted during reset are discarded; first valid sample is the first rising edge with rst_n high.

Configuration
REQ-036 Macro COHERENT_CACHE_EXCL_EN defined: EXCLUSIVE stored and reported; BusRd EXCLUSIVE->SHARED; snp_dirty=0 for EXCLUSIVE; evict_dirty=0 for EXCLUSIVE.
REQ-037 Macro undefined: wr_state EXCLUSIVE stored as SHARED; state 3 never output.

Verification
REQ-038 Reset, then rd_en addr=0x041 -> hit=0, rd_state=INVALID, evict_dirty=0.
REQ-039 wr_en addr=0x041 data=0x1111 MODIFIED; rd_en 0x041 -> hit=1, rd_data=0x1111, rd_state=MODIFIED.
REQ-040 WAYS=2: write tags 1 and 2 to set 1, read tag 1, read tag 3 -> hit=0, evict_tag=2.
REQ-041 Line MODIFIED, snp_valid snp_inv=0 -> snp_hit=1, snp_dirty=1, snp_data=line; later rd_state=SHARED.
REQ-042 wr_en SHARED and snp_valid snp_inv=1 same edge, same addr -> snp_hit=1, snp_data=wr_data, later lookup hit=0.
REQ-043 COHERENT_CACHE_EXCL_EN defined, write EXCLUSIVE, snp_inv=0 -> snp_dirty=0, then rd_state=SHARED; macro undefined -> rd_state=SHARED straight after the write.
